seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised multi-cycle ALU, WIDTH bits wide.
- Single-cycle ops: add, sub.
- Iterative ops: multiply (shift-add), divide and modulo (restoring).
- Interface: start/busy/done handshake, registered result and error flag.
- Sits between the command decoder and the display/result path; replaces the grounded mul/div/mod channels of the current combinational datapath.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request; sampled only when busy=0.
command  input  4  opcode: 0 nop, 1 add, 2 sub, 3 mul, 4 div, 5 mod, 6-15 illegal.
inputA  input  WIDTH  operand A.
inputB  input  WIDTH  operand B.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result/error valid.
result  output  WIDTH  operation result, held until next accepted start.
error  output  1  error flag, held with result.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation): busy=0, done=0, result=0, error=0, FSM=IDLE, counter=0, internal operand/accumulator regs=0. Takes effect immediately, without waiting for a clock edge.
- Latching: at edge N with busy=0 and start=1, latch inputA, inputB, command. Set busy=1. Later input changes are ignored.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on accepted start.
  - RUN -> IDLE when the iteration count reaches L.
  - At that same edge: done=1 for exactly one cycle, busy=0, result/error updated.
- Latency L (edges from accept to done assertion):
  - 1 for nop, add, sub, illegal opcode, div/mod with B=0.
  - WIDTH for mul, div, mod with B!=0.
- Back-to-back: start is accepted in the cycle done=1 (busy=0 there); no bubble required.
- start while busy=1 is ignored: no queueing, no error.
- nop: result=0, error=0.
- add/sub: two's complement, WIDTH bits. Sub is A + ~B + 1. error = carry-in XOR carry-out of the MSB (signed overflow).
- mul: unsigned, 2*WIDTH-bit product built by shift-add, one bit of B per cycle.
  - result = product[WIDTH-1:0].
  - error = 1 iff product[2W-1:W] != 0.
- div/mod: unsigned restoring division, one quotient bit per cycle, MSB first.
  - div result = quotient; mod result = remainder; error=0.
- Divide by zero (B=0, div or mod): result = all ones, error=1, L=1.
- Illegal opcode: result=0, error=1, L=1.
- result/error change only at done assertion or reset; never glitch mid-operation.

Optional Feature:
Macro SEQ_ALU_HI_EN.
- Defined:
  - Adds output result_hi (WIDTH).
  - mul: result_hi = product[2W-1:W].
  - div: result_hi = remainder; mod: result_hi = quotient.
  - All other ops: result_hi = 0.
  - result_hi has the same reset, hold and timing as result.
  - error rules are unchanged.
- Undefined: port result_hi is absent; no upper-half or secondary registers are kept beyond those the algorithms need.

Test Plan (WIDTH=4):
- Reset, then add A=6 B=1, 1-cycle start -> done 1 edge after accept, result=7, error=0. Then add A=7 B=1 -> result=8 (4'b1000), error=1.
- sub A=2 B=5 -> result=4'b1101, error=0, latency 1. Immediately issue a new start in the done cycle -> accepted, busy=1 next cycle.
- mul A=3 B=5 -> done 4 edges after accept, result=15, error=0. mul A=5 B=4 -> result=4, error=1 (result_hi=1 with SEQ_ALU_HI_EN).
- div A=13 B=4 -> result=3, error=0, latency 4. mod A=13 B=4 -> result=1. div A=9 B=0 -> result=4'b1111, error=1, latency 1. command=9 -> result=0, error=1.
- Start mul A=7 B=7. Pulse start with add during busy -> ignored; final result=1 (49 mod 16), error=1.
- Start mul A=7 B=7. Assert rst_n=0 after 2 cycles -> busy/done/result/error=0 immediately, without waiting for a clock edge. Release reset; next add A=1 B=1 -> result=2.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake.
// add/sub/nop/illegal and divide-by-zero finish one edge after accept.
// mul (shift-add) and div/mod (restoring) finish WIDTH edges after accept.
// Optional output result_hi (upper product half / secondary quotient or
// remainder) is built only when SEQ_ALU_HI_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start; done pulses here for one cycle
// S_RUN  | operation in progress, cnt_q counts down the iterations left
module seq_alu #(
    parameter int  WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SEQ_ALU_HI_EN
    output logic [WIDTH-1:0] result_hi,
`endif
    output logic             error
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    // a_q: multiplicand, or dividend shifting into the quotient
    // b_q: multiplier shifting into the product low half, or divisor
    // acc_q: product high half, or partial remainder
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               error_q, error_d, done_q, done_d;
`ifdef SEQ_ALU_HI_EN
    logic [WIDTH-1:0]   hi_q, hi_d;
`endif

    logic               accept, finish, iter_start, b_zero;
    logic [WIDTH-1:0]   bop;
    logic [WIDTH:0]     as_full;
    logic               as_err;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_lo, mul_hi;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_rem, div_quo;
    logic [WIDTH-1:0]   fin_res, fin_hi;
    logic               fin_err;

    assign accept     = (state_q == S_IDLE) && start;
    assign finish     = (state_q == S_RUN) && (cnt_q == '0);
    assign b_zero     = (b_q == '0);
    assign iter_start = (command == OP_MUL) ||
                        (((command == OP_DIV) || (command == OP_MOD)) && (inputB != '0));

    // add/sub with signed overflow taken from the carries around the MSB
    always_comb begin
        bop     = (op_q == OP_SUB) ? ~b_q : b_q;
        as_full = {1'b0, a_q} + {1'b0, bop} + (WIDTH+1)'(op_q == OP_SUB);
        as_err  = (a_q[WIDTH-1] ^ bop[WIDTH-1] ^ as_full[WIDTH-1]) ^ as_full[WIDTH];
    end

    // one shift-add step: add multiplicand if multiplier LSB set, shift right
    always_comb begin
        mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};
    end

    // one restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        div_part = {acc_q, a_q[WIDTH-1]};
        div_ge   = (div_part >= {1'b0, b_q});
        div_diff = div_part[WIDTH-1:0] - b_q;
        div_rem  = div_ge ? div_diff : div_part[WIDTH-1:0];
        div_quo  = {a_q[WIDTH-2:0], div_ge};
    end

    // result/error/hi values to publish on the finishing edge
    always_comb begin
        fin_res = '0;
        fin_err = 1'b0;
        fin_hi  = '0;
        case (op_q)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin
                fin_res = as_full[WIDTH-1:0];
                fin_err = as_err;
            end
            OP_MUL: begin
                fin_res = mul_lo;
                fin_hi  = mul_hi;
                fin_err = |mul_hi;
            end
            OP_DIV, OP_MOD: begin
                if (b_zero) begin
                    fin_res = '1;
                    fin_err = 1'b1;
                end else begin
                    fin_res = (op_q == OP_DIV) ? div_quo : div_rem;
                    fin_hi  = (op_q == OP_DIV) ? div_rem : div_quo;
                end
            end
            default: fin_err = 1'b1;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        busy = (state_q == S_RUN);
    end

    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;
`ifdef SEQ_ALU_HI_EN
    assign result_hi = hi_q;
`endif

    // datapath next values: latch on accept, iterate while running
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        done_d   = 1'b0;
`ifdef SEQ_ALU_HI_EN
        hi_d     = hi_q;
`endif
        if (accept) begin
            a_d   = inputA;
            b_d   = inputB;
            acc_d = '0;
            op_d  = command;
            cnt_d = iter_start ? CNT_W'(WIDTH - 1) : '0;
        end else if (state_q == S_RUN) begin
            if (op_q == OP_MUL) begin
                acc_d = mul_hi;
                b_d   = mul_lo;
            end else if (((op_q == OP_DIV) || (op_q == OP_MOD)) && !b_zero) begin
                acc_d = div_rem;
                a_d   = div_quo;
            end
            if (finish) begin
                done_d   = 1'b1;
                result_d = fin_res;
                error_d  = fin_err;
`ifdef SEQ_ALU_HI_EN
                hi_d     = fin_hi;
`endif
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

`ifndef SEQ_ALU_HI_EN
    logic unused_hi;
    assign unused_hi = ^fin_hi;
`endif

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_HI_EN
            hi_q     <= '0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
            done_q   <= done_d;
`ifdef SEQ_ALU_HI_EN
            hi_q     <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   command;
    logic [W-1:0] inputA, inputB;
    logic         busy, done, error;
    logic [W-1:0] result;
`ifdef SEQ_ALU_HI_EN
    logic [W-1:0] result_hi;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .command   (command),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .result    (result),
`ifdef SEQ_ALU_HI_EN
        .result_hi (result_hi),
`endif
        .error     (error)
    );

    // reference model from the arithmetic definition of each opcode
    task automatic model(input int cmd, input int a, input int b,
                         output int res, output int err, output int hi, output int lat);
        int m, h, sa, sb, v, p;
        m = 1 << W;
        h = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        res = 0; err = 0; hi = 0; lat = 1;
        case (cmd)
            0: ;
            1: begin res = (a + b) % m; v = sa + sb; err = (v >= h || v < -h) ? 1 : 0; end
            2: begin res = (a - b + m) % m; v = sa - sb; err = (v >= h || v < -h) ? 1 : 0; end
            3: begin p = a * b; res = p % m; hi = p / m; err = (hi != 0) ? 1 : 0; lat = W; end
            4, 5: begin
                if (b == 0) begin
                    res = m - 1; err = 1;
                end else begin
                    res = (cmd == 4) ? a / b : a % b;
                    hi  = (cmd == 4) ? a % b : a / b;
                    lat = W;
                end
            end
            default: err = 1;
        endcase
    endtask

    // drive one operation, return what the DUT produced and how long it took
    task automatic run_op(input int cmd, input int a, input int b, input int pulse_at,
                          output logic [W-1:0] res, output logic err, output logic [W-1:0] hi,
                          output int lat, output logic busy_acc, output bit glitch,
                          output bit timeout);
        logic [W-1:0] r0;
        @(negedge clk);
        start = 1'b1; command = cmd[3:0]; inputA = a[W-1:0]; inputB = b[W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        busy_acc = busy;
        r0 = result;
        command = 4'($urandom); inputA = W'($urandom); inputB = W'($urandom);
        lat = 0; timeout = 1'b1; glitch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == pulse_at) begin start = 1'b1; command = 4'd1; end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done === 1'b1) begin timeout = 1'b0; break; end
            if (result !== r0 || busy !== 1'b1) glitch = 1'b1;
        end
        res = result;
        err = error;
`ifdef SEQ_ALU_HI_EN
        hi = result_hi;
`else
        hi = '0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; command = '0; inputA = '0; inputB = '0;
        #12;
        checks += 4;
        if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (result !== '0)   begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
        if (error !== 1'b0)  begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int cv[4] = '{1, 1, 2, 2};
        int av[4] = '{6, 7, 2, 8};
        int bv[4] = '{1, 1, 5, 1};
        int er, ee, eh, el, lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        for (int i = 0; i < 4; i++) begin
            model(cv[i], av[i], bv[i], er, ee, eh, el);
            run_op(cv[i], av[i], bv[i], -1, r, e, h, lat, ba, g, t);
            checks += 3;
            if (t || lat != el) begin errors++; $display("FAIL addsub_latency case=%0d got=%0d exp=%0d", i, lat, el); end
            if (r !== W'(er))   begin errors++; $display("FAIL addsub_result case=%0d got=%0d exp=%0d", i, r, er); end
            if (e !== ee[0])    begin errors++; $display("FAIL addsub_error case=%0d got=%b exp=%0d", i, e, ee); end
        end
    endtask

    task automatic test_mul_div();
        int cv[5] = '{3, 3, 4, 5, 3};
        int av[5] = '{3, 5, 13, 13, 15};
        int bv[5] = '{5, 4, 4, 4, 15};
        int er, ee, eh, el, lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        for (int i = 0; i < 5; i++) begin
            model(cv[i], av[i], bv[i], er, ee, eh, el);
            run_op(cv[i], av[i], bv[i], -1, r, e, h, lat, ba, g, t);
            checks += 4;
            if (t || lat != el) begin errors++; $display("FAIL iter_latency case=%0d got=%0d exp=%0d", i, lat, el); end
            if (r !== W'(er))   begin errors++; $display("FAIL iter_result case=%0d got=%0d exp=%0d", i, r, er); end
            if (e !== ee[0])    begin errors++; $display("FAIL iter_error case=%0d got=%b exp=%0d", i, e, ee); end
            if (g)              begin errors++; $display("FAIL iter_hold case=%0d got=changed exp=held", i); end
`ifdef SEQ_ALU_HI_EN
            checks++;
            if (h !== W'(eh))   begin errors++; $display("FAIL iter_hi case=%0d got=%0d exp=%0d", i, h, eh); end
`endif
        end
    endtask

    task automatic test_errors();
        int cv[4] = '{4, 5, 9, 15};
        int av[4] = '{9, 3, 5, 1};
        int bv[4] = '{0, 0, 5, 2};
        int er, ee, eh, el, lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        for (int i = 0; i < 4; i++) begin
            model(cv[i], av[i], bv[i], er, ee, eh, el);
            run_op(cv[i], av[i], bv[i], -1, r, e, h, lat, ba, g, t);
            checks += 3;
            if (t || lat != el) begin errors++; $display("FAIL err_latency case=%0d got=%0d exp=%0d", i, lat, el); end
            if (r !== W'(er))   begin errors++; $display("FAIL err_result case=%0d got=%0d exp=%0d", i, r, er); end
            if (e !== ee[0])    begin errors++; $display("FAIL err_error case=%0d got=%b exp=%0d", i, e, ee); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        run_op(2, 2, 5, -1, r, e, h, lat, ba, g, t);
        checks += 3;
        if (t || r !== 4'b1101 || e !== 1'b0) begin errors++; $display("FAIL b2b_first got=%0d/%b exp=13/0", r, e); end
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle got=%b exp=1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done got=%b exp=0", busy); end
        run_op(1, 3, 4, -1, r, e, h, lat, ba, g, t);
        checks += 2;
        if (ba !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", ba); end
        if (t || lat != 1 || r !== W'(7)) begin errors++; $display("FAIL b2b_second got=%0d lat=%0d exp=7 lat=1", r, lat); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        run_op(3, 7, 7, 1, r, e, h, lat, ba, g, t);
        checks += 3;
        if (t || lat != W) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W); end
        if (r !== W'(1))   begin errors++; $display("FAIL ignore_result got=%0d exp=1", r); end
        if (e !== 1'b1)    begin errors++; $display("FAIL ignore_error got=%b exp=1", e); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        @(negedge clk);
        start = 1'b1; command = 4'd3; inputA = W'(7); inputB = W'(7);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)  begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (result !== '0)  begin errors++; $display("FAIL midrst_result got=%0d exp=0", result); end
        if (error !== 1'b0) begin errors++; $display("FAIL midrst_error got=%b exp=0", error); end
        @(negedge clk); rst_n = 1'b1;
        run_op(1, 1, 1, -1, r, e, h, lat, ba, g, t);
        checks++;
        if (t || lat != 1 || r !== W'(2) || e !== 1'b0) begin
            errors++; $display("FAIL midrst_after got=%0d/%b lat=%0d exp=2/0 lat=1", r, e, lat);
        end
    endtask

    task automatic test_random();
        int c, a, b, er, ee, eh, el, lat;
        logic [W-1:0] r, h; logic e, ba; bit g, t;
        for (int i = 0; i < 60; i++) begin
            c = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            model(c, a, b, er, ee, eh, el);
            run_op(c, a, b, -1, r, e, h, lat, ba, g, t);
            checks += 4;
            if (t || lat != el) begin errors++; $display("FAIL rand_latency op=%0d a=%0d b=%0d got=%0d exp=%0d", c, a, b, lat, el); end
            if (r !== W'(er))   begin errors++; $display("FAIL rand_result op=%0d a=%0d b=%0d got=%0d exp=%0d", c, a, b, r, er); end
            if (e !== ee[0])    begin errors++; $display("FAIL rand_error op=%0d a=%0d b=%0d got=%b exp=%0d", c, a, b, e, ee); end
            if (g)              begin errors++; $display("FAIL rand_hold op=%0d a=%0d b=%0d got=changed exp=held", c, a, b); end
`ifdef SEQ_ALU_HI_EN
            checks++;
            if (h !== W'(eh))   begin errors++; $display("FAIL rand_hi op=%0d a=%0d b=%0d got=%0d exp=%0d", c, a, b, h, eh); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul_div();
        test_errors();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
